// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//   Multi-cycle branch resolution for the CPU control path. A branch op is
//   started from IDLE. Jumps and calls then collect an ADDR_BYTES-wide target
//   from the data bus, most-significant byte first. Returns resolve straight
//   away from the internal return-address stack. Once the op resolves, the
//   block emits a one-cycle done pulse, and a pc_load pulse as well when the
//   branch is taken and legal.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               begin a branch op (only looked at in IDLE)
//   cond[3:0]           condition select, latched at start
//   mode[1:0]           0 abs jump, 1 rel jump, 2 call, 3 return
//   pcin[AW-1:0]        next sequential PC, latched at start (relative base,
//                       call return address)
//   zflag/cflag/oflag/sflag  ALU flags, latched at start
//   byte_valid, databus operand byte stream, MSB first
//   busy                high while operand bytes are being collected
//   done                one-cycle pulse when the op resolves
//   pc_load, pc_out     PC load strobe and target (pc_out is 0 when no load)
//   stack_err           sticky stack overflow/underflow, cleared by rst
//   sp_level            return-address stack occupancy
// -----------------------------------------------------------------------------
module branch_unit #(
    parameter  int DATA_W      = 8,
    parameter  int ADDR_BYTES  = 2,
    parameter  int STACK_DEPTH = 8,
    localparam int AW          = DATA_W * ADDR_BYTES,
    localparam int SPW         = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cond,
    input  logic [1:0]        mode,
    input  logic [AW-1:0]     pcin,
    input  logic              zflag,
    input  logic              cflag,
    input  logic              oflag,
    input  logic              sflag,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] databus,
    output logic              busy,
    output logic              done,
    output logic              pc_load,
    output logic [AW-1:0]     pc_out,
    output logic              stack_err,
    output logic [SPW-1:0]    sp_level
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    localparam int             IW       = SPW - 1;
    localparam int             CW       = $clog2(ADDR_BYTES + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(ADDR_BYTES - 1);
    localparam logic [SPW-1:0] FULL_LVL = SPW'(STACK_DEPTH);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    cond_q;
    logic [1:0]    mode_q;
    logic [3:0]    flags_q;      // {z, c, o, s}
    logic [AW-1:0] pc_q;
    logic [AW-1:0] opnd;
    logic [AW-1:0] opnd_next;
    logic [SPW-1:0] sp;
    logic [AW-1:0] stack_mem [STACK_DEPTH];

    // The operand register shifts left one byte per accepted byte. The
    // final byte arrives on the same edge that resolves the op, so
    // resolution looks at the post-shift value.
    generate
        if (ADDR_BYTES == 1) begin : g_one_byte
            assign opnd_next = databus;
        end else begin : g_multi_byte
            assign opnd_next = {opnd[AW-DATA_W-1:0], databus};
        end
    endgenerate

    // Flag vector layout: {z, c, o, s}. o^s is the signed less-than flag.
    function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, lt;
        z  = f[3];
        cy = f[2];
        lt = f[1] ^ f[0];
        case (c)
            4'd0:    cond_met = 1'b1;
            4'd1:    cond_met = z;
            4'd2:    cond_met = !z;
            4'd3:    cond_met = cy;
            4'd4:    cond_met = cy | z;
            4'd5:    cond_met = !(cy | z);
            4'd6:    cond_met = !cy;
            4'd7:    cond_met = lt;
            4'd8:    cond_met = lt | z;
            4'd9:    cond_met = !(lt | z);
            4'd10:   cond_met = !lt;
            default: cond_met = 1'b0;
        endcase
    endfunction

    logic          in_idle, accept, last_byte, resolve;
    logic [1:0]    r_mode;
    logic [3:0]    r_cond, r_flags;
    logic          taken, legal, load;
    logic [AW-1:0] target;
    logic          push, pop, err_set;
    logic [IW-1:0] top_idx;

    // A return resolves in IDLE on the start edge, so it has to use the live
    // inputs. Every other op resolves from the values latched at start.
    always_comb begin
        // NOTE: every signal gets a default before the branches below. Any
        // path that left one unassigned would infer a latch.
        in_idle   = (state == S_IDLE);
        accept    = in_idle && start;
        last_byte = !in_idle && byte_valid && (cnt == LAST_CNT);
        resolve   = (accept && (mode == 2'd3)) || last_byte;
        r_mode    = in_idle ? mode : mode_q;
        r_cond    = in_idle ? cond : cond_q;
        r_flags   = in_idle ? {zflag, cflag, oflag, sflag} : flags_q;
        taken     = cond_met(r_cond, r_flags);
        top_idx   = sp[IW-1:0] - IW'(1);
        target    = '0;
        legal     = 1'b0;
        case (r_mode)
            2'd0: begin target = opnd_next;        legal = 1'b1;         end
            2'd1: begin target = pc_q + opnd_next; legal = 1'b1;         end
            2'd2: begin target = opnd_next;        legal = (sp != FULL_LVL); end
            default: begin target = stack_mem[top_idx]; legal = (sp != '0); end
        endcase
        load    = resolve && taken && legal;
        push    = load && (r_mode == 2'd2);
        pop     = load && (r_mode == 2'd3);
        err_set = resolve && taken && !legal;
    end

    assign busy     = (state == S_FETCH);
    assign sp_level = sp;

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever order the lines are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cond_q    <= '0;
            mode_q    <= '0;
            flags_q   <= '0;
            pc_q      <= '0;
            opnd      <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
            done      <= 1'b0;
            pc_load   <= 1'b0;
            pc_out    <= '0;
        end else begin
            done    <= resolve;
            pc_load <= load;
            pc_out  <= load ? target : '0;

            if (push)
                sp <= sp + SPW'(1);
            else if (pop)
                sp <= sp - SPW'(1);

            if (err_set)
                stack_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cond_q  <= cond;
                        mode_q  <= mode;
                        flags_q <= {zflag, cflag, oflag, sflag};
                        pc_q    <= pcin;
                        cnt     <= '0;
                        if (mode != 2'd3)
                            state <= S_FETCH;
                    end
                end
                default: begin
                    if (byte_valid) begin
                        opnd <= opnd_next;
                        if (cnt == LAST_CNT)
                            state <= S_IDLE;
                        else
                            cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // NOTE: the stack storage is deliberately not reset. sp alone decides
    // which entries are valid, so clearing sp empties the stack.
    always_ff @(posedge clk) begin
        if (push)
            stack_mem[sp[IW-1:0]] <= pc_q;
    end

endmodule
